// File: rtl/minefield_pkg.sv
// Shared types and constants for the minefield builder.
package minefield_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        PICK,
        PLACE,
        NEIGH,
        DONE
    } state_t;

    typedef logic [2:0] dir_t;

    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [31:0] MINE = '1;

    // Neighbour order: row above left to right, same row, row below.
    function automatic logic signed [1:0] dir_dx(dir_t d);
        unique case (d)
            3'd0, 3'd3, 3'd5: return -2'sd1;
            3'd1, 3'd6:       return 2'sd0;
            default:          return 2'sd1;
        endcase
    endfunction

    function automatic logic signed [1:0] dir_dy(dir_t d);
        unique case (d)
            3'd0, 3'd1, 3'd2: return -2'sd1;
            3'd3, 3'd4:       return 2'sd0;
            default:          return 2'sd1;
        endcase
    endfunction

endpackage

// File: rtl/minefield_builder_lfsr16.sv
// 16-bit Galois LFSR (taps 16,14,13,11) with load and step enable.
module lfsr16
    import minefield_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        enable,
    input  logic [15:0] seed,
    output logic [15:0] value,
    output logic [15:0] next
);

    assign next = value[0] ? ((value >> 1) ^ LFSR_TAPS) : (value >> 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= DEFAULT_SEED;
        end else if (load) begin
            value <= seed;
        end else if (enable) begin
            value <= next;
        end
    end

endmodule

// File: rtl/minefield_builder.sv
// Minefield builder: clears the board, places mines, bumps neighbour counts.
// Optional SAFE_START_EN keeps (safeX,safeY) free of mines.
module minefield_builder
    import minefield_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int HEIGHT    = 8,
    parameter int BUS_WIDTH = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [$clog2(WIDTH*HEIGHT+1)-1:0]    numMines,
    input  logic [15:0]                          seed,
    input  logic [$clog2(WIDTH)-1:0]             safeX,
    input  logic [$clog2(HEIGHT)-1:0]            safeY,
    output logic                                 busy,
    output logic                                 done,
    output logic [$clog2(WIDTH)-1:0]             rdX,
    output logic [$clog2(HEIGHT)-1:0]            rdY,
    input  logic [BUS_WIDTH-1:0]                 rdValue,
    output logic                                 wrEn,
    output logic [$clog2(WIDTH)-1:0]             wrX,
    output logic [$clog2(HEIGHT)-1:0]            wrY,
    output logic [BUS_WIDTH-1:0]                 wrValue
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int CELLS = WIDTH * HEIGHT;
    localparam int NW = $clog2(CELLS + 1);
    localparam logic [BUS_WIDTH-1:0] MINE_V = MINE[BUS_WIDTH-1:0];
    localparam logic [NW-1:0] MAX_T = NW'(CELLS - 1);

    state_t state, state_n;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    dir_t dir;
    logic [NW-1:0] cnt, target;

    logic accept;
    logic [15:0] seed_in, lval, lnext, csrc;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic x_ok, y_ok, safe_hit, is_mine;
    logic signed [1:0] dxv, dyv;
    logic signed [XW+1:0] nx;
    logic signed [YW+1:0] ny;
    logic n_ok, clear_last;

    assign accept  = (state == IDLE) && start;
    assign seed_in = (seed == 16'd0) ? DEFAULT_SEED : seed;

    lfsr16 u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .enable (state == PICK),
        .seed   (seed_in),
        .value  (lval),
        .next   (lnext)
    );

    // PICK looks at the value the LFSR is about to hold; once accepted,
    // the LFSR register itself remembers the candidate for PLACE/NEIGH.
    assign csrc = (state == PICK) ? lnext : lval;
    assign px   = csrc[XW-1:0];
    assign py   = csrc[XW+YW-1:XW];
    assign x_ok = {1'b0, px} < (XW+1)'(WIDTH);
    assign y_ok = {1'b0, py} < (YW+1)'(HEIGHT);
    assign is_mine = (rdValue == MINE_V);

`ifdef SAFE_START_EN
    assign safe_hit = (px == safeX) && (py == safeY);
    logic unused_bits;
    assign unused_bits = ^csrc[15:XW+YW];
`else
    assign safe_hit = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{csrc[15:XW+YW], safeX, safeY};
`endif

    assign dxv = dir_dx(dir);
    assign dyv = dir_dy(dir);
    assign nx  = $signed({2'b00, px}) + $signed({{XW{dxv[1]}}, dxv});
    assign ny  = $signed({2'b00, py}) + $signed({{YW{dyv[1]}}, dyv});
    assign n_ok = !nx[XW+1] && (nx[XW:0] < (XW+1)'(WIDTH))
               && !ny[YW+1] && (ny[YW:0] < (YW+1)'(HEIGHT));

    assign clear_last = (cx == XW'(WIDTH - 1)) && (cy == YW'(HEIGHT - 1));

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);

    always_comb begin
        state_n = state;
        rdX     = '0;
        rdY     = '0;
        wrEn    = 1'b0;
        wrX     = '0;
        wrY     = '0;
        wrValue = '0;
        unique case (state)
            IDLE: begin
                if (start) state_n = CLEAR;
            end
            CLEAR: begin
                wrEn = 1'b1;
                wrX  = cx;
                wrY  = cy;
                if (clear_last) state_n = (target == '0) ? DONE : PICK;
            end
            PICK: begin
                rdX = px;
                rdY = py;
                if (x_ok && y_ok && !safe_hit && !is_mine) state_n = PLACE;
            end
            PLACE: begin
                wrEn    = 1'b1;
                wrX     = px;
                wrY     = py;
                wrValue = MINE_V;
                state_n = NEIGH;
            end
            NEIGH: begin
                if (n_ok) begin
                    rdX = nx[XW-1:0];
                    rdY = ny[YW-1:0];
                    if (!is_mine) begin
                        wrEn    = 1'b1;
                        wrX     = nx[XW-1:0];
                        wrY     = ny[YW-1:0];
                        wrValue = rdValue + BUS_WIDTH'(1);
                    end
                end
                if (dir == 3'd7) begin
                    state_n = (cnt + NW'(1) == target) ? DONE : PICK;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cx     <= '0;
            cy     <= '0;
            dir    <= '0;
            cnt    <= '0;
            target <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                target <= (numMines > MAX_T) ? MAX_T : numMines;
                cnt    <= '0;
                cx     <= '0;
                cy     <= '0;
            end
            if (state == CLEAR) begin
                if (cx == XW'(WIDTH - 1)) begin
                    cx <= '0;
                    cy <= (cy == YW'(HEIGHT - 1)) ? '0 : cy + YW'(1);
                end else begin
                    cx <= cx + XW'(1);
                end
            end
            if (state == PLACE) dir <= '0;
            if (state == NEIGH) begin
                dir <= dir + 3'd1;
                if (dir == 3'd7) cnt <= cnt + NW'(1);
            end
        end
    end

endmodule

// File: tb/tb_minefield_builder.sv
// Self-checking bench for minefield_builder with a board RAM model.
module tb_minefield_builder;

    localparam int W = 8;
    localparam int H = 8;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [6:0] numMines;
    logic [15:0] seed;
    logic [2:0] safeX, safeY;
    logic       busy, done;
    logic [2:0] rdX, rdY, wrX, wrY;
    logic [7:0] rdValue, wrValue;
    logic       wrEn;

    always #5 clk = ~clk;

    minefield_builder #(
        .WIDTH(W), .HEIGHT(H), .BUS_WIDTH(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .numMines(numMines), .seed(seed),
        .safeX(safeX), .safeY(safeY),
        .busy(busy), .done(done),
        .rdX(rdX), .rdY(rdY), .rdValue(rdValue),
        .wrEn(wrEn), .wrX(wrX), .wrY(wrY), .wrValue(wrValue)
    );

    logic [7:0] board [N];
    logic [13:0] wlog [$];

    assign rdValue = board[{rdY, rdX}];

    always @(posedge clk) begin
        if (wrEn) begin
            board[{wrY, wrX}] <= wrValue;
            wlog.push_back({wrY, wrX, wrValue});
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference model: replay the pseudo-random sequence, then derive counts.
    logic [7:0] expb [N];
    int exp_lat;

    function automatic logic [15:0] lstep(input logic [15:0] s);
        logic fb;
        fb = s[0];
        s = {1'b0, s[15:1]};
        if (fb) begin
            s[15] = ~s[15];
            s[13] = ~s[13];
            s[12] = ~s[12];
            s[10] = ~s[10];
        end
        return s;
    endfunction

    task automatic model(input int nm, input logic [15:0] sd);
        bit mine [N];
        int tgt, cnt, steps, x, y, c;
        logic [15:0] s;
        tgt = (nm > N - 1) ? N - 1 : nm;
        s = (sd == 16'd0) ? 16'hACE1 : sd;
        for (int i = 0; i < N; i++) mine[i] = 0;
        cnt = 0;
        steps = 0;
        while (cnt < tgt && steps < 200000) begin
            s = lstep(s);
            steps++;
            x = int'(s[2:0]);
            y = int'(s[5:3]);
`ifdef SAFE_START_EN
            if (x == int'(safeX) && y == int'(safeY)) continue;
`endif
            if (!mine[y*W+x]) begin
                mine[y*W+x] = 1;
                cnt++;
            end
        end
        for (int cy = 0; cy < H; cy++) begin
            for (int cx = 0; cx < W; cx++) begin
                c = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if ((dx != 0 || dy != 0) && cx+dx >= 0 && cx+dx < W
                            && cy+dy >= 0 && cy+dy < H && mine[(cy+dy)*W+cx+dx])
                            c++;
                expb[cy*W+cx] = mine[cy*W+cx] ? 8'hFF : 8'(c);
            end
        end
        exp_lat = 1 + N + steps + 9 * tgt;
    endtask

    task automatic run_build(input int nm, input logic [15:0] sd,
                             input bit glitch, input string tag,
                             output int lat);
        int viol, bad_order, late_done;
        logic [13:0] e;
        logic [5:0] ii;
        model(nm, sd);
        wlog.delete();
        @(negedge clk);
        numMines = 7'(nm);
        seed = sd;
        start = 1'b1;
        lat = 0;
        viol = 0;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < exp_lat + 200) begin
            if (wrEn && !busy) viol++;
            if (!busy) viol++;
            start = glitch && (lat == 10 || lat == exp_lat - 3);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk({tag, " done_seen"}, int'(done), 1);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " busy_wr_rule"}, viol, 0);
        chk({tag, " busy_at_done"}, int'(busy), 0);
        late_done = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done || busy || wrEn) late_done++;
        end
        chk({tag, " quiet_after_done"}, late_done, 0);
        bad_order = 0;
        if (wlog.size() < N) begin
            bad_order = N;
        end else begin
            for (int i = 0; i < N; i++) begin
                ii = 6'(i);
                e = {ii, 8'h00};
                if (wlog[i] != e) bad_order++;
            end
        end
        chk({tag, " clear_order"}, bad_order, 0);
        for (int i = 0; i < N; i++)
            chk($sformatf("%s cell%0d", tag, i), int'(board[i]), int'(expb[i]));
    endtask

    function automatic int count_mines();
        int m;
        m = 0;
        for (int i = 0; i < N; i++) if (board[i] == 8'hFF) m++;
        return m;
    endfunction

    typedef struct {
        int          nm;
        logic [15:0] sd;
        int          lat;
        int          mines;
    } vec_t;

    vec_t tbl [4];
    int lat;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        numMines = '0;
        seed = '0;
        safeX = 3'd3;
        safeY = 3'd4;
        for (int i = 0; i < N; i++) board[i] = 8'h55;

        tbl[0] = '{nm: 0,  sd: 16'h1234, lat: 65, mines: 0};
        tbl[1] = '{nm: 1,  sd: 16'h0001, lat: 75, mines: 1};
        tbl[2] = '{nm: 70, sd: 16'h5A5A, lat: -1, mines: 63};
        tbl[3] = '{nm: 5,  sd: 16'h0000, lat: -1, mines: 5};

        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset wrEn", int'(wrEn), 0);
        chk("reset rd", int'({rdX, rdY}), 0);
        chk("reset wr", int'({wrX, wrY, wrValue}), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int t = 0; t < 4; t++) begin
            run_build(tbl[t].nm, tbl[t].sd, 1'b0, $sformatf("vec%0d", t), lat);
            if (tbl[t].lat >= 0) chk($sformatf("vec%0d table_lat", t), lat, tbl[t].lat);
            chk($sformatf("vec%0d mines", t), count_mines(), tbl[t].mines);
        end

        for (int r = 0; r < 4; r++)
            run_build(int'($urandom_range(0, 70)), 16'($urandom), 1'b0,
                      $sformatf("rnd%0d", r), lat);

        run_build(10, 16'hC0DE, 1'b1, "glitch", lat);
        chk("glitch mines", count_mines(), 10);

        // Abort in the middle of the neighbour pass of the only mine.
        @(negedge clk);
        numMines = 7'd1;
        seed = 16'h0001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (69) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort busy", int'(busy), 0);
        chk("abort wrEn", int'(wrEn), 0);
        chk("abort done", int'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        run_build(7, 16'($urandom), 1'b0, "after_abort", lat);

`ifdef SAFE_START_EN
        run_build(63, 16'hBEEF, 1'b0, "safe", lat);
        chk("safe cell", int'(board[4*W+3]), 8);
        chk("safe mines", count_mines(), 63);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
